// File: rtl/mips_mc_core_pkg.sv
// +----------------------------------------------------------------------------
// | mips_mc_core_pkg : state encodings, opcode/funct and fault constants
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package mips_mc_core_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_st_fetch  = 3'd0;
    localparam state_t c_st_decode = 3'd1;
    localparam state_t c_st_exec   = 3'd2;
    localparam state_t c_st_mem    = 3'd3;
    localparam state_t c_st_wb     = 3'd4;
    localparam state_t c_st_halt   = 3'd5;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_jal   = 6'h03;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_addiu = 6'h09;
    localparam logic [5:0] c_op_ori   = 6'h0D;
    localparam logic [5:0] c_op_lui   = 6'h0F;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    localparam logic [5:0] c_fn_sll  = 6'h00;
    localparam logic [5:0] c_fn_jr   = 6'h08;
    localparam logic [5:0] c_fn_addu = 6'h21;
    localparam logic [5:0] c_fn_subu = 6'h23;
    localparam logic [5:0] c_fn_and  = 6'h24;
    localparam logic [5:0] c_fn_or   = 6'h25;
    localparam logic [5:0] c_fn_slt  = 6'h2A;

    localparam logic [1:0] c_fault_none     = 2'b00;
    localparam logic [1:0] c_fault_illegal  = 2'b01;
    localparam logic [1:0] c_fault_timeout  = 2'b10;
    localparam logic [1:0] c_fault_misalign = 2'b11;

    function automatic logic is_legal(input logic [31:0] ir);
        logic [5:0] op;
        logic [5:0] fn;
        op = ir[31:26];
        fn = ir[5:0];
        case (op)
            c_op_rtype: return fn inside {c_fn_sll, c_fn_jr, c_fn_addu, c_fn_subu,
                                          c_fn_and, c_fn_or, c_fn_slt};
            c_op_j, c_op_jal, c_op_beq, c_op_bne, c_op_addiu,
            c_op_ori, c_op_lui, c_op_lw, c_op_sw: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_mc_core_regfile.sv
// +----------------------------------------------------------------------------
// | mc_regfile : 32x32 GPR file, 2 async read ports, 1 sync write, $0 hardwired
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module mc_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);

    logic [31:0] r_regs [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (i_we && (i_wa != 5'd0)) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : r_regs[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : r_regs[i_ra2];

endmodule

`default_nettype wire

// File: rtl/mips_mc_core.sv
// +----------------------------------------------------------------------------
// | mips_mc_core : multi-cycle MIPS subset core with one unified memory port
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module mips_mc_core
    import mips_mc_core_pkg::*;
#(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = AW'(32'h0000_3000),
    parameter int            TIMEOUT  = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack,
    output logic          halted,
    output logic [1:0]    fault_code,
    output logic [AW-1:0] pc_dbg
);

    state_t        r_state, w_state_next;
    logic [AW-1:0] r_pc, w_pc4, w_br_tgt, w_j_tgt, w_pc_exec;
    logic [31:0]   r_ir, r_a, r_b, r_imm, r_alu, r_mdr;
    logic [31:0]   w_alu, w_imm, w_rd1, w_rd2, w_wd;
    logic [7:0]    r_wait, w_wait_inc;
    logic [1:0]    r_fault, w_fault_next;
    logic [5:0]    w_op, w_fn;
    logic [4:0]    w_wa;
    logic          w_legal, w_is_mem, w_is_ctrl, w_timeout, w_we;

    assign w_op       = r_ir[31:26];
    assign w_fn       = r_ir[5:0];
    assign w_legal    = is_legal(r_ir);
    assign w_is_mem   = (w_op == c_op_lw) || (w_op == c_op_sw);
    assign w_is_ctrl  = (w_op == c_op_beq) || (w_op == c_op_bne) || (w_op == c_op_j) ||
                        (w_op == c_op_jal) || ((w_op == c_op_rtype) && (w_fn == c_fn_jr));
    assign w_wait_inc = r_wait + 8'd1;
    assign w_timeout  = !mem_ack && (w_wait_inc == 8'(TIMEOUT));

    assign w_pc4    = r_pc + AW'(4);
    assign w_br_tgt = w_pc4 + {{(AW-18){r_ir[15]}}, r_ir[15:0], 2'b00};
    assign w_j_tgt  = {w_pc4[AW-1:28], r_ir[25:0], 2'b00};

    always_comb begin
        w_pc_exec = w_pc4;
        case (w_op)
            c_op_beq:           if (r_a == r_b) w_pc_exec = w_br_tgt;
            c_op_bne:           if (r_a != r_b) w_pc_exec = w_br_tgt;
            c_op_j, c_op_jal:   w_pc_exec = w_j_tgt;
            c_op_rtype:         w_pc_exec = AW'(r_a);
            default:            w_pc_exec = w_pc4;
        endcase
    end

    always_comb begin
        case (w_op)
            c_op_ori: w_imm = {16'd0, r_ir[15:0]};
            c_op_lui: w_imm = {r_ir[15:0], 16'd0};
            default:  w_imm = {{16{r_ir[15]}}, r_ir[15:0]};
        endcase
    end

    // Default covers addiu and the lw/sw effective address.
    always_comb begin
        w_alu = r_a + r_imm;
        case (w_op)
            c_op_rtype: begin
                case (w_fn)
                    c_fn_subu: w_alu = r_a - r_b;
                    c_fn_and:  w_alu = r_a & r_b;
                    c_fn_or:   w_alu = r_a | r_b;
                    c_fn_slt:  w_alu = {31'd0, $signed(r_a) < $signed(r_b)};
                    c_fn_sll:  w_alu = r_b << r_ir[10:6];
                    default:   w_alu = r_a + r_b;
                endcase
            end
            c_op_ori: w_alu = r_a | r_imm;
            c_op_lui: w_alu = r_imm;
            default:  w_alu = r_a + r_imm;
        endcase
    end

    // jal links in EXEC; every other register write happens in WB.
    assign w_we = (r_state == c_st_wb) || ((r_state == c_st_exec) && (w_op == c_op_jal));
    assign w_wa = (r_state == c_st_exec) ? 5'd31 :
                  (w_op == c_op_rtype)   ? r_ir[15:11] : r_ir[20:16];
    assign w_wd = (r_state == c_st_exec) ? 32'(w_pc4) :
                  (w_op == c_op_lw)      ? r_mdr : r_alu;

    mc_regfile u_regfile (
        .clk   (Clk),
        .rst   (Reset),
        .i_ra1 (r_ir[25:21]),
        .i_ra2 (r_ir[20:16]),
        .i_we  (w_we),
        .i_wa  (w_wa),
        .i_wd  (w_wd),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2)
    );

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= c_st_fetch;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_fault_next = r_fault;
        case (r_state)
            c_st_fetch: begin
                if (mem_ack) begin
                    w_state_next = c_st_decode;
                end else if (w_timeout) begin
                    w_state_next = c_st_halt;
                    w_fault_next = c_fault_timeout;
                end
            end
            c_st_decode: w_state_next = c_st_exec;
            c_st_exec: begin
                if (!w_legal) begin
                    w_state_next = c_st_halt;
                    w_fault_next = c_fault_illegal;
                end else if (w_is_mem && (w_alu[1:0] != 2'b00)) begin
                    w_state_next = c_st_halt;
                    w_fault_next = c_fault_misalign;
                end else if (w_is_mem) begin
                    w_state_next = c_st_mem;
                end else if (w_is_ctrl) begin
                    w_state_next = c_st_fetch;
                end else begin
                    w_state_next = c_st_wb;
                end
            end
            c_st_mem: begin
                if (mem_ack) begin
                    w_state_next = (w_op == c_op_lw) ? c_st_wb : c_st_fetch;
                end else if (w_timeout) begin
                    w_state_next = c_st_halt;
                    w_fault_next = c_fault_timeout;
                end
            end
            c_st_wb:   w_state_next = c_st_fetch;
            c_st_halt: w_state_next = c_st_halt;
            default:   w_state_next = c_st_halt;
        endcase
    end

    always_comb begin
        mem_req    = !Reset && ((r_state == c_st_fetch) || (r_state == c_st_mem));
        mem_we     = !Reset && (r_state == c_st_mem) && (w_op == c_op_sw);
        mem_addr   = (r_state == c_st_mem) ? AW'(r_alu) : r_pc;
        mem_wdata  = r_b;
        halted     = (r_state == c_st_halt);
        fault_code = r_fault;
        pc_dbg     = Reset ? RESET_PC : r_pc;
    end

    // PC holds the address of the instruction in progress until it retires.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pc    <= RESET_PC;
            r_ir    <= 32'd0;
            r_wait  <= 8'd0;
            r_fault <= c_fault_none;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_imm   <= 32'd0;
            r_alu   <= 32'd0;
            r_mdr   <= 32'd0;
        end else begin
            r_fault <= w_fault_next;
            if (w_state_next != r_state) begin
                r_wait <= 8'd0;
            end else if (((r_state == c_st_fetch) || (r_state == c_st_mem)) && !mem_ack) begin
                r_wait <= w_wait_inc;
            end
            case (r_state)
                c_st_fetch: if (mem_ack) r_ir <= mem_rdata;
                c_st_decode: begin
                    r_a   <= w_rd1;
                    r_b   <= w_rd2;
                    r_imm <= w_imm;
                end
                c_st_exec: begin
                    r_alu <= w_alu;
                    if (w_state_next == c_st_fetch) r_pc <= w_pc_exec;
                end
                c_st_mem: begin
                    if (mem_ack) r_mdr <= mem_rdata;
                    if (mem_ack && (w_op == c_op_sw)) r_pc <= w_pc4;
                end
                c_st_wb: r_pc <= w_pc4;
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mips_mc_core.sv
// +----------------------------------------------------------------------------
// | tb_mips_mc_core : directed programs against a wait-state memory model
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_mips_mc_core;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        mem_req, mem_we, halted;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_addr, mem_wdata, pc_dbg;
    logic [31:0] mem_rdata = 32'd0;
    logic [1:0]  fault_code;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rel_cyc = 0;

    logic [31:0] mem [0:4095];
    int          wait_cfg = 0;
    int          wait_cnt = 0;
    bit          spurious = 1'b0;
    logic [31:0] hold_addr, hold_wdata;
    logic        hold_we;
    int          unstable = 0;
    int          req_cycles = 0;
    logic [31:0] rd_addr_q[$];
    int          rd_cyc_q[$];
    logic [31:0] st_addr_q[$];
    logic [31:0] st_data_q[$];

    localparam logic [31:0] P1 [6] = '{32'h34011234, 32'h00211021, 32'hAC020000,
                                       32'h8C030000, 32'hAC030004, 32'h1000FFFF};
    localparam logic [31:0] P1_RD  [8] = '{32'h3000, 32'h3004, 32'h3008, 32'h300C,
                                           32'h0000, 32'h3010, 32'h3014, 32'h3014};
    localparam int          P1_CYC [8] = '{0, 4, 8, 12, 15, 17, 21, 24};
    localparam logic [31:0] PB_ST_A [7] = '{32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd28};
    localparam logic [31:0] PB_ST_D [7] = '{32'h00003010, 32'hFFFFFFFC, 32'hFFFFFFF5, 32'h1,
                                            32'h70, 32'hABCD0004, 32'h0};

    mips_mc_core dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .halted     (halted),
        .fault_code (fault_code),
        .pc_dbg     (pc_dbg)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory model: acks after wait_cfg stall cycles, logs reads, writes and hold stability.
    initial begin
        forever begin
            @(negedge Clk);
            mem_ack   = 1'b0;
            mem_rdata = 32'hDEAD_BEEF;
            if (Reset) begin
                wait_cnt = 0;
            end else if (mem_req) begin
                req_cycles++;
                if (wait_cnt == 0) begin
                    hold_addr  = mem_addr;
                    hold_we    = mem_we;
                    hold_wdata = mem_wdata;
                    if (!mem_we) begin
                        rd_addr_q.push_back(mem_addr);
                        rd_cyc_q.push_back(cyc);
                    end
                end else if (mem_addr !== hold_addr || mem_we !== hold_we ||
                             mem_wdata !== hold_wdata) begin
                    unstable++;
                end
                if (wait_cnt >= wait_cfg) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem[mem_addr[13:2]] = mem_wdata;
                        st_addr_q.push_back(mem_addr);
                        st_data_q.push_back(mem_wdata);
                    end else begin
                        mem_rdata = mem[mem_addr[13:2]];
                    end
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                if (spurious) begin
                    mem_ack   = 1'b1;
                    mem_rdata = 32'hFC00_0000;
                end
            end
        end
    end

    task automatic put(input logic [31:0] a, input logic [31:0] w);
        mem[a[13:2]] = w;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    endtask

    task automatic load_p1();
        clear_mem();
        for (int i = 0; i < 6; i++) put(32'h3000 + 32'(4 * i), P1[i]);
    endtask

    task automatic do_reset(input string tag);
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check_eq({tag, "_rst_req"}, {31'd0, mem_req}, 32'd0);
        check_eq({tag, "_rst_we"}, {31'd0, mem_we}, 32'd0);
        check_eq({tag, "_rst_pc"}, pc_dbg, 32'h3000);
        rd_addr_q.delete();
        rd_cyc_q.delete();
        st_addr_q.delete();
        st_data_q.delete();
        unstable   = 0;
        req_cycles = 0;
        Reset      = 1'b0;
        rel_cyc    = cyc;
    endtask

    task automatic wait_reads(input string tag, input int n, input int budget);
        int k = 0;
        while (rd_addr_q.size() < n && k < budget) begin
            @(posedge Clk);
            k++;
        end
        #1;
        check_eq({tag, "_reads_seen"}, 32'(rd_addr_q.size() >= n), 32'd1);
    endtask

    task automatic wait_halt(input string tag, input int budget);
        int k = 0;
        while (!halted && k < budget) begin
            @(posedge Clk);
            k++;
        end
        #1;
        check_eq({tag, "_halted"}, {31'd0, halted}, 32'd1);
    endtask

    function automatic logic [31:0] rd_at(input int i);
        return (i < rd_addr_q.size()) ? rd_addr_q[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < rd_cyc_q.size()) ? rd_cyc_q[i] - rel_cyc : -1;
    endfunction

    task automatic check_stores(input string tag, input int n,
                                input logic [31:0] ea [], input logic [31:0] ed []);
        check_eq({tag, "_st_count"}, 32'(st_addr_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_st_addr%0d", tag, i),
                     (i < st_addr_q.size()) ? st_addr_q[i] : 32'hFFFF_FFFF, ea[i]);
            check_eq($sformatf("%s_st_data%0d", tag, i),
                     (i < st_data_q.size()) ? st_data_q[i] : 32'hFFFF_FFFF, ed[i]);
        end
    endtask

    initial begin
        logic [31:0] p1_sa [];
        logic [31:0] p1_sd [];
        logic [31:0] pb_sa [];
        logic [31:0] pb_sd [];
        p1_sa = new[2];
        p1_sd = new[2];
        p1_sa[0] = 32'd0;      p1_sa[1] = 32'd4;
        p1_sd[0] = 32'h2468;   p1_sd[1] = 32'h2468;
        pb_sa = new[7];
        pb_sd = new[7];
        for (int i = 0; i < 7; i++) begin
            pb_sa[i] = PB_ST_A[i];
            pb_sd[i] = PB_ST_D[i];
        end

        // Zero-wait run of P1: reset release, latencies, store data.
        load_p1();
        wait_cfg = 0;
        do_reset("p1z");
        #1;
        check_eq("p1z_first_req", {31'd0, mem_req}, 32'd1);
        check_eq("p1z_first_addr", mem_addr, 32'h3000);
        check_eq("p1z_first_we", {31'd0, mem_we}, 32'd0);
        wait_reads("p1z", 8, 100);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("p1z_rd_addr%0d", i), rd_at(i), P1_RD[i]);
            check_eq($sformatf("p1z_rd_cyc%0d", i), 32'(cyc_at(i)), 32'(P1_CYC[i]));
        end
        check_stores("p1z", 2, p1_sa, p1_sd);

        // Same program with 3 wait states per access.
        load_p1();
        wait_cfg = 3;
        do_reset("p1w");
        wait_reads("p1w", 8, 300);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("p1w_rd_addr%0d", i), rd_at(i), P1_RD[i]);
        end
        check_eq("p1w_ori_latency", 32'(cyc_at(1) - cyc_at(0)), 32'd7);
        check_stores("p1w", 2, p1_sa, p1_sd);
        check_eq("p1w_unstable", 32'(unstable), 32'd0);

        // Program B: branch loop, jal, ALU mix, jr, $0 write, illegal opcode; stray acks.
        clear_mem();
        put(32'h3000, 32'h34010007);  // ori   $1,$0,7
        put(32'h3004, 32'h2404FFFC);  // addiu $4,$0,-4
        put(32'h3008, 32'h1000FFFF);  // beq   $0,$0,-1
        put(32'h300C, 32'h0C000C08);  // jal   0x3020
        put(32'h3020, 32'hAC1F0004);  // sw    $31,4($0)
        put(32'h3024, 32'hAC040008);  // sw    $4,8($0)
        put(32'h3028, 32'h00812823);  // subu  $5,$4,$1
        put(32'h302C, 32'h0081302A);  // slt   $6,$4,$1
        put(32'h3030, 32'h00013900);  // sll   $7,$1,4
        put(32'h3034, 32'h3C08ABCD);  // lui   $8,0xABCD
        put(32'h3038, 32'h01014825);  // or    $9,$8,$1
        put(32'h303C, 32'h01245024);  // and   $10,$9,$4
        put(32'h3040, 32'h00210021);  // addu  $0,$1,$1
        put(32'h3044, 32'h340B3054);  // ori   $11,$0,0x3054
        put(32'h3048, 32'h01600008);  // jr    $11
        put(32'h304C, 32'hFC000000);
        put(32'h3050, 32'hFC000000);
        put(32'h3054, 32'hAC05000C);  // sw    $5,12($0)
        put(32'h3058, 32'hAC060010);  // sw    $6,16($0)
        put(32'h305C, 32'hAC070014);  // sw    $7,20($0)
        put(32'h3060, 32'hAC0A0018);  // sw    $10,24($0)
        put(32'h3064, 32'hAC00001C);  // sw    $0,28($0)
        put(32'h3068, 32'hFC000000);  // illegal
        wait_cfg = 0;
        spurious = 1'b1;
        do_reset("pb");
        wait_reads("pb", 4, 100);
        check_eq("pb_beq_rd2", rd_at(2), 32'h3008);
        check_eq("pb_beq_rd3", rd_at(3), 32'h3008);
        check_eq("pb_beq_latency", 32'(cyc_at(3) - cyc_at(2)), 32'd3);
        put(32'h3008, 32'h1400FFFF);  // bne $0,$0,-1 (not taken)
        wait_halt("pb", 600);
        check_stores("pb", 7, pb_sa, pb_sd);
        check_eq("pb_fault", {30'd0, fault_code}, 32'd1);
        check_eq("pb_pc_dbg", pc_dbg, 32'h3068);
        check_eq("pb_req_off", {31'd0, mem_req}, 32'd0);
        spurious = 1'b0;

        // Fetch never acknowledged: halt after exactly 16 request cycles.
        clear_mem();
        wait_cfg = 1000;
        do_reset("to");
        repeat (15) @(posedge Clk);
        #1;
        check_eq("to_not_yet_halted", {31'd0, halted}, 32'd0);
        check_eq("to_still_req", {31'd0, mem_req}, 32'd1);
        @(posedge Clk);
        #1;
        check_eq("to_halted", {31'd0, halted}, 32'd1);
        check_eq("to_fault", {30'd0, fault_code}, 32'd2);
        check_eq("to_req_off", {31'd0, mem_req}, 32'd0);
        check_eq("to_pc_dbg", pc_dbg, 32'h3000);
        load_p1();
        wait_cfg = 0;
        do_reset("to2");
        #1;
        check_eq("to2_halted", {31'd0, halted}, 32'd0);
        check_eq("to2_fault", {30'd0, fault_code}, 32'd0);
        check_eq("to2_req", {31'd0, mem_req}, 32'd1);
        check_eq("to2_addr", mem_addr, 32'h3000);

        // Misaligned lw: fault without any data request.
        clear_mem();
        put(32'h3000, 32'h8C030002);  // lw $3,2($0)
        wait_cfg = 0;
        do_reset("mis");
        repeat (10) @(posedge Clk);
        #1;
        check_eq("mis_halted", {31'd0, halted}, 32'd1);
        check_eq("mis_fault", {30'd0, fault_code}, 32'd3);
        check_eq("mis_req_cycles", 32'(req_cycles), 32'd1);
        check_eq("mis_pc_dbg", pc_dbg, 32'h3000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_mc_core.md
MIPS_MC_CORE -- requirements
Module: mips_mc_core

Interface
REQ-001 Parameter AW, default 32: width of the byte address on mem_addr and of the PC.
REQ-002 Parameter RESET_PC, default 32'h0000_3000: PC value loaded on reset.
REQ-003 Parameter TIMEOUT, default 16: maximum cycles a memory request waits for mem_ack before the core faults; legal range 1..255.
REQ-004 Clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset, sampled on the rising edge of Clk.
REQ-006 mem_req  out  1  memory request valid.
REQ-007 mem_we  out  1  request is a word write when 1, a read when 0.
REQ-008 mem_addr  out  AW  word-aligned byte address of the request.
REQ-009 mem_wdata  out  32  write data.
REQ-010 mem_rdata  in  32  read data, valid in the cycle mem_ack=1.
REQ-011 mem_ack  in  1  one-cycle completion strobe for the current request.
REQ-012 halted  out  1  core stopped by an illegal opcode or a memory timeout.
REQ-013 fault_code  out  2  00 none, 01 illegal opcode, 10 memory timeout, 11 misaligned address.
REQ-014 pc_dbg  out  AW  architectural PC of the instruction in progress.

Function
REQ-015 The core SHALL be a multi-cycle MIPS core with one unified memory port, using the states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-016 The supported instructions SHALL be addu, subu, slt, and, or, sll, ori, lui, addiu, lw, sw, beq, bne, j, jal and jr; any other encoding SHALL go to HALT with fault_code=01.
REQ-017 In FETCH the core SHALL assert mem_req=1, mem_we=0 and mem_addr=PC; on mem_ack it SHALL latch IR and go to DECODE.
REQ-018 In DECODE the core SHALL read rs and rt, sign- or zero-extend the immediate, and always go to EXEC.
REQ-019 EXEC routing:
- ALU ops go to WB.
- lw and sw compute rs+signext(imm) and go to MEM.
- beq, bne, j and jr update the PC and go to FETCH.
- jal writes PC+4 to $31 and goes to FETCH.
REQ-020 In MEM the core SHALL hold mem_req, mem_we, mem_addr and mem_wdata stable until mem_ack.
- On mem_ack, lw goes to WB and sw goes to FETCH.
REQ-021 In WB the core SHALL write rd (R-type), rt (I-type) or the loaded word to the register file, then go to FETCH.
REQ-022 Writes to $0 SHALL be discarded, and $0 SHALL always read as 0.
REQ-023 The sequential PC SHALL be PC+4.
- Branch target: PC+4+(signext(imm)<<2).
- j/jal target: {PC+4[AW-1:28], target26, 2'b00}.
- All PC arithmetic wraps modulo 2^AW.
REQ-024 Latency with zero-wait memory (mem_ack in the first request cycle):
- ALU ops: 4 cycles.
- lw: 5 cycles.
- sw: 4 cycles.
- Branches and jumps: 3 cycles.
REQ-025 A wait counter SHALL clear on entry to FETCH or MEM and count each cycle without mem_ack.
- When it reaches TIMEOUT, the core enters HALT with fault_code=10 and drops mem_req.
REQ-026 A lw/sw address with addr[1:0]!=0 SHALL enter HALT with fault_code=11 without issuing mem_req.
REQ-027 mem_ack received while mem_req=0 SHALL be ignored.
REQ-028 In HALT: mem_req=0, halted=1, and pc_dbg frozen at the faulting instruction; only Reset exits HALT.
REQ-029 Arithmetic SHALL be 32-bit two's complement with no overflow trap.
- slt is signed.
- sll uses shamt[4:0].

Reset
REQ-030 On Reset=1 the core SHALL load the following on that clock edge, without waiting for any outstanding mem_ack:
- PC=RESET_PC, state=FETCH, IR=0, wait counter=0.
- halted=0, fault_code=00, all GPRs=0.
REQ-031 While Reset=1: mem_req=0, mem_we=0, and pc_dbg=RESET_PC.
REQ-032 The first cycle after Reset deasserts SHALL drive mem_req=1 with mem_addr=RESET_PC.

Structure
REQ-033 A shared package SHALL hold the state enum, opcode and funct constants, and the fault_code encodings.
REQ-034 The register file SHALL be the one sub-module, mc_regfile: 32x32, 2 read ports, 1 write port, with synchronous reset clearing every register.

Verification
REQ-035 Reset release with zero-wait memory: the first mem_req is seen with mem_addr=32'h3000 and mem_we=0.
REQ-036 ori $1,$0,0x1234 then addu $2,$1,$1: $2=32'h2468, and each instruction takes 4 cycles.
REQ-037 sw $2,0($0) then lw $3,0($0) with 3 wait cycles per access: mem_wdata=32'h2468, $3=32'h2468, and mem signals stay stable while waiting.
REQ-038 beq $0,$0,-1 at 32'h3008: the next fetch address is 32'h3008; jal at 32'h300C: $31=32'h3010.
REQ-039 mem_ack withheld for 16 cycles in FETCH: halted=1, fault_code=10, mem_req=0; Reset then restarts at 32'h3000.
REQ-040 Illegal opcode 6'b111111: halted=1 and fault_code=01; lw with address 32'h2 gives fault_code=11 and no mem_req.
